wb_stage: RTL

Writeback stage of the CPU pipeline, directly upstream of the register file. It accepts retiring instructions from the memory stage over a valid/ready handshake and waits for load data from the data memory. It extracts and sign- or zero-extends load bytes, then drives the register file write port (`wrr`/`wrdata`/`wr_en`). It also exports a bypass and a pending-load tag so decode can forward or stall.

---
 rtl/wb_pkg.sv | 18 +
 rtl/load_extract.sv | 56 +++++
 rtl/wb_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extract.sv
// Load data lane selection and sign/zero extension, plus illegal/misaligned
// detection for a funct3/offset pair. Purely combinational.
module load_extract
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            bad
);

  function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] v);
    logic signed [XLEN-1:0] w;
    w = v;
    return w;
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] v);
    logic signed [XLEN-1:0] w;
    w = v;
    return w;
  endfunction

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[8*offset +: 8];
  assign half_v = rdata[16*offset[1] +: 16];

  // Select the addressed lane and extend it; flag unsupported or misaligned accesses.
  always_comb begin
    data = '0;
    bad  = 1'b0;
    case (funct3)
      F3_LB:  data = sext8(byte_v);
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH: begin
        data = sext16(half_v);
        bad  = offset[0];
      end
      F3_LHU: begin
        data = {{(XLEN-16){1'b0}}, half_v};
        bad  = offset[0];
      end
      F3_LW: begin
        data = rdata;
        bad  = (offset != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts retiring instructions, waits for load data,
// extends it and drives the register file write port, bypass and load tag.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int REG_AW       = REG_AW_DEF,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_result,
  input  logic              in_is_load,
  input  logic [2:0]        in_funct3,
  input  logic              in_wb_en,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [REG_AW-1:0] wrr,
  output logic [XLEN-1:0]   wrdata,
  output logic              wr_en,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_rd,
  output logic              retire,
  output logic              fault
);

  localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_t         state;
  logic [CNT_W-1:0]  wait_cnt;

  // Load context captured at accept (stage p0 = outstanding load).
  logic [REG_AW-1:0] ld_rd_p0;
  logic [2:0]        ld_f3_p0;
  logic [1:0]        ld_off_p0;
  logic              ld_wben_p0;

  // Extractor shared between accept-time legality check and data return.
  logic [2:0]        ext_f3;
  logic [1:0]        ext_off;
  logic [XLEN-1:0]   ext_data;
  logic              ext_bad;

  assign ext_f3  = (state == S_WAIT_LOAD) ? ld_f3_p0  : in_funct3;
  assign ext_off = (state == S_WAIT_LOAD) ? ld_off_p0 : in_result[1:0];

  load_extract #(.XLEN(XLEN)) u_extract (
    .funct3 (ext_f3),
    .offset (ext_off),
    .rdata  (mem_rdata),
    .data   (ext_data),
    .bad    (ext_bad)
  );

  assign in_ready  = (state == S_IDLE);
  assign fwd_valid = wr_en;
  assign fwd_rd    = wrr;
  assign fwd_data  = wrdata;

  logic accept;
  assign accept = in_valid && (state == S_IDLE);

  // Capture load context on every load accept; consumed only in WAIT_LOAD.
  always_ff @(posedge clk) begin
    if (accept && in_is_load) begin
      ld_rd_p0   <= in_rd;
      ld_f3_p0   <= in_funct3;
      ld_off_p0  <= in_result[1:0];
      ld_wben_p0 <= in_wb_en;
    end
  end

  // FSM, timeout counter and registered write/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      wr_en      <= 1'b0;
      wrr        <= '0;
      wrdata     <= '0;
      pend_valid <= 1'b0;
      pend_rd    <= '0;
      retire     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      wr_en  <= 1'b0;
      retire <= 1'b0;
      fault  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (!in_is_load) begin
              retire <= 1'b1;
              if (in_wb_en && (in_rd != '0)) begin
                wr_en  <= 1'b1;
                wrr    <= in_rd;
                wrdata <= in_result;
              end
            end else if (ext_bad) begin
              retire <= 1'b1;
              fault  <= 1'b1;
            end else begin
              state      <= S_WAIT_LOAD;
              wait_cnt   <= '0;
              pend_valid <= 1'b1;
              pend_rd    <= in_rd;
            end
          end
        end
        S_WAIT_LOAD: begin
          // Returning data takes priority over a timeout in the same cycle.
          if (mem_rvalid) begin
            state      <= S_IDLE;
            pend_valid <= 1'b0;
            retire     <= 1'b1;
            if (ld_wben_p0 && (ld_rd_p0 != '0)) begin
              wr_en  <= 1'b1;
              wrr    <= ld_rd_p0;
              wrdata <= ext_data;
            end
          end else if (wait_cnt == CNT_LAST) begin
            state      <= S_IDLE;
            pend_valid <= 1'b0;
            retire     <= 1'b1;
            fault      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
